// File: rtl/host_cycle_sync_if.sv
// Host-access sequencing bus: edge/request inputs toward the sequencer,
// clock-select / RDY / status outputs back, plus an FSM state debug tap.
interface host_cycle_sync_if;
  logic       host_edge;
  logic       req;
  logic       sel_host;
  logic       cpu_rdy;
  logic       done;
  logic       timeout;
  logic [1:0] state_dbg;

  // master: edge detector + CPU request side; slave: the sequencer itself
  modport master (
    output host_edge, req,
    input  sel_host, cpu_rdy, done, timeout, state_dbg
  );

  modport slave (
    input  host_edge, req,
    output sel_host, cpu_rdy, done, timeout, state_dbg
  );
endinterface

// File: rtl/host_cycle_sync.sv
// Sequences a CPU host-bus access: stall, sync to a host edge, run on the
// host clock for HOST_EDGES cycles, hold LEAD_CYCLES fast clocks, release.
module host_cycle_sync #(
  parameter int HOST_EDGES  = 1,
  parameter int LEAD_CYCLES = 2,
  parameter int TIMEOUT     = 255,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              srst,
  host_cycle_sync_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    ACCESS  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] EDGE_LOAD = CNT_W'(HOST_EDGES - 1);
  localparam logic [CNT_W-1:0] LEAD_LOAD = CNT_W'((LEAD_CYCLES == 0) ? 0 : LEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_n;
  logic             sel_q, sel_n;
  logic             rdy_q, rdy_n;
  logic             done_q, done_n;
  logic             to_q, to_n;
  logic [CNT_W-1:0] wait_q, wait_n;
  logic [CNT_W-1:0] edge_q, edge_n;
  logic [CNT_W-1:0] lead_q, lead_n;

  // Falling edge: the same edge the host edge detector uses.
  always_ff @(negedge clk) begin
    if (srst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      rdy_q   <= 1'b1;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      wait_q  <= '0;
      edge_q  <= '0;
      lead_q  <= '0;
    end else begin
      state_q <= state_n;
      sel_q   <= sel_n;
      rdy_q   <= rdy_n;
      done_q  <= done_n;
      to_q    <= to_n;
      wait_q  <= wait_n;
      edge_q  <= edge_n;
      lead_q  <= lead_n;
    end
  end

  always_comb begin
    state_n = state_q;
    sel_n   = sel_q;
    rdy_n   = rdy_q;
    done_n  = 1'b0;
    to_n    = to_q;
    wait_n  = wait_q;
    edge_n  = edge_q;
    lead_n  = lead_q;

    unique case (state_q)
      // host_edge is deliberately ignored here so a pulse coincident with
      // req can never serve as the sync edge.
      IDLE: begin
        if (bus.req) begin
          state_n = SYNC;
          rdy_n   = 1'b0;
          wait_n  = '0;
        end
      end

      SYNC: begin
        if (bus.host_edge) begin
          state_n = ACCESS;
          sel_n   = 1'b1;
          edge_n  = EDGE_LOAD;
        end else if (!bus.req) begin
          state_n = IDLE;
          rdy_n   = 1'b1;
        end else if (wait_q == WAIT_LAST) begin
          state_n = IDLE;
          rdy_n   = 1'b1;
          to_n    = 1'b1;
        end else begin
          wait_n  = wait_q + 1'b1;
        end
      end

      // Committed: req is no longer looked at until the access completes.
      ACCESS: begin
        if (bus.host_edge) begin
          if (edge_q != '0) begin
            edge_n = edge_q - 1'b1;
          end else if (LEAD_CYCLES == 0) begin
            state_n = IDLE;
            sel_n   = 1'b0;
            rdy_n   = 1'b1;
            done_n  = 1'b1;
          end else begin
            state_n = RELEASE;
            lead_n  = LEAD_LOAD;
          end
        end
      end

      RELEASE: begin
        if (lead_q == '0) begin
          state_n = IDLE;
          sel_n   = 1'b0;
          rdy_n   = 1'b1;
          done_n  = 1'b1;
        end else begin
          lead_n  = lead_q - 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.sel_host  = sel_q;
  assign bus.cpu_rdy   = rdy_q;
  assign bus.done      = done_q;
  assign bus.timeout   = to_q;
  assign bus.state_dbg = state_q;

endmodule
